// File: rtl/rv6_mem_pkg.sv
// Shared memory-side definitions for the rv6 data cache and its refill engine.
// Line geometry, bus burst-length width and refill FSM encoding live here.
package rv6_mem_pkg;

   localparam int DMEM_LINE    = 256;
   localparam int DMEM_BLK_LEN = 59;
   localparam int DMEM_BEATS   = DMEM_LINE / 64;
   localparam int BUS_LEN_W    = 8;

   // S_HOLD is reserved and never entered.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_BEAT = 3'd2,
      S_DONE = 3'd3,
      S_HOLD = 3'd4
   } refill_state_t;

endpackage

// File: rtl/dmem_refill.sv
// Data-cache line refill: one burst read of BEATS 64-bit beats per request,
// assembled into a full line and returned with a single valid pulse.
module dmem_refill
   import rv6_mem_pkg::*;
#(
   parameter int LINE    = DMEM_LINE,
   parameter int BLK_LEN = DMEM_BLK_LEN,
   parameter int BEATS   = LINE / 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BLK_LEN-1:0]   b_addr_d,
   input  logic                 b_rd_d,
   output logic [LINE-1:0]      b_rdata_d,
   output logic                 b_dv_d,
   output logic                 b_err_d,
   output logic [63:0]          m_addr,
   output logic [BUS_LEN_W-1:0] m_len,
   output logic                 m_req,
   input  logic                 m_ack,
   input  logic [63:0]          m_rdata,
   input  logic                 m_rvalid,
   input  logic                 m_rerr
);

   localparam int OFF   = $clog2(LINE / 8);
   localparam int CNT_W = $clog2(BEATS);

   refill_state_t state_q;
   refill_state_t state_d;

   logic [BLK_LEN-1:0] blk_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               err_q;
   logic               abort_q;
   logic [LINE-1:0]    line_q;

   logic beat;
   logic last;
   logic busy;

   assign beat = (state_q == S_BEAT) && m_rvalid;
   assign last = (cnt_q == CNT_W'(BEATS - 1));
   assign busy = (state_q == S_REQ) || (state_q == S_BEAT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blk_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         if ((state_q == S_IDLE) && b_rd_d) begin
            blk_q   <= b_addr_d;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
         end
         if (beat) begin
            cnt_q <= cnt_q + 1'b1;
            err_q <= err_q | m_rerr;
         end
         // A dropped request still drains the burst; only the pulse is lost.
         if (busy && !b_rd_d) begin
            abort_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && beat) begin
         line_q[64*cnt_q +: 64] <= m_rdata;
      end
   end

   always_comb begin
      state_d = state_q;
      m_req   = 1'b0;
      m_addr  = '0;
      b_dv_d  = 1'b0;
      b_err_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (b_rd_d) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            m_req  = 1'b1;
            m_addr = 64'({blk_q, {OFF{1'b0}}});
            if (m_ack) begin
               state_d = S_BEAT;
            end
         end
         S_BEAT: begin
            if (beat && last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            b_dv_d  = !abort_q;
            b_err_d = !abort_q && err_q;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign m_len     = BUS_LEN_W'(BEATS - 1);
   assign b_rdata_d = line_q;

endmodule
